// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the decode/execute datapath and pipe_hazard_ctrl.
// master = datapath side (drives hazard inputs), slave = controller (drives enables/selects/counters).
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rw;
    logic                  ex_w_en;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] mem_rw;
    logic                  mem_w_en;
    logic                  ex_syscall;
    logic                  ex_syscall_halt;
    logic                  branch_taken;
    logic                  resume;

    logic                  pc_en;
    logic                  ps1_en;
    logic                  ps2_en;
    logic                  ps1_flush;
    logic                  ps2_flush;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  halted;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic [CNT_W-1:0]      halt_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_rw, ex_w_en, ex_is_load, mem_rw, mem_w_en,
        output ex_syscall, ex_syscall_halt, branch_taken, resume,
        input  pc_en, ps1_en, ps2_en, ps1_flush, ps2_flush,
        input  fwd_a_sel, fwd_b_sel, halted,
        input  stall_cnt, flush_cnt, halt_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_rw, ex_w_en, ex_is_load, mem_rw, mem_w_en,
        input  ex_syscall, ex_syscall_halt, branch_taken, resume,
        output pc_en, ps1_en, ps2_en, ps1_flush, ps2_flush,
        output fwd_a_sel, fwd_b_sel, halted,
        output stall_cnt, flush_cnt, halt_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ID/EX pipeline hazard controller: load-use stall, branch flush, halt drain, operand forwarding.
// Optional macro HAZARD_PERF_CNT_EN builds the stall/flush/halt performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic              clk,
    input logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = {REG_ADDR_W{1'b0}};
    localparam logic [3:0]            DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    // EX wins over MEM; a load in EX cannot forward because its data is not ready yet.
    function automatic logic [1:0] fwd_sel(
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] ex_rw,
        input logic                  ex_w_en,
        input logic                  ex_is_load,
        input logic [REG_ADDR_W-1:0] mem_rw,
        input logic                  mem_w_en
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (!uses) begin
            sel = 2'd0;
        end else if (ex_w_en && !ex_is_load && (ex_rw != REG_ZERO) && (ex_rw == src)) begin
            sel = 2'd1;
        end else if (mem_w_en && (mem_rw != REG_ZERO) && (mem_rw == src)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] drain_q, drain_d;

    logic       ldu_s;
    logic       hlt_s;
    logic       pc_en_s;
    logic       ps1_en_s;
    logic       ps2_en_s;
    logic       ps1_flush_s;
    logic       ps2_flush_s;
    logic       halted_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    assign ldu_s = hz.ex_is_load && hz.ex_w_en && (hz.ex_rw != REG_ZERO) &&
                   ((hz.id_uses_rs && (hz.id_rs == hz.ex_rw)) ||
                    (hz.id_uses_rt && (hz.id_rt == hz.ex_rw)));
    assign hlt_s = hz.ex_syscall && hz.ex_syscall_halt;

    // State and drain-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and pipeline control decode; priority in RUN is halt > branch > load-use.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_en_s     = 1'b0;
        ps1_en_s    = 1'b0;
        ps2_en_s    = 1'b0;
        ps1_flush_s = 1'b0;
        ps2_flush_s = 1'b0;
        halted_s    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hlt_s) begin
                    ps2_en_s    = 1'b1;
                    ps2_flush_s = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_d     = DRAIN_LOAD;
                end else if (hz.branch_taken) begin
                    pc_en_s     = 1'b1;
                    ps1_en_s    = 1'b1;
                    ps2_en_s    = 1'b1;
                    ps1_flush_s = 1'b1;
                    ps2_flush_s = 1'b1;
                end else if (ldu_s) begin
                    ps2_en_s    = 1'b1;
                    ps2_flush_s = 1'b1;
                end else begin
                    pc_en_s  = 1'b1;
                    ps1_en_s = 1'b1;
                    ps2_en_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 4'd0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            ST_HALTED: begin
                halted_s = 1'b1;
                if (hz.resume) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_RUN;
                drain_d = 4'd0;
            end
        endcase
    end

    // Forwarding selects, independent of pipeline state.
    always_comb begin
        fwd_a_s = fwd_sel(hz.id_uses_rs, hz.id_rs, hz.ex_rw, hz.ex_w_en, hz.ex_is_load,
                          hz.mem_rw, hz.mem_w_en);
        fwd_b_s = fwd_sel(hz.id_uses_rt, hz.id_rt, hz.ex_rw, hz.ex_w_en, hz.ex_is_load,
                          hz.mem_rw, hz.mem_w_en);
    end

    // Outputs are forced quiet for as long as reset is held, without waiting for a clock.
    assign hz.pc_en     = rst_n & pc_en_s;
    assign hz.ps1_en    = rst_n & ps1_en_s;
    assign hz.ps2_en    = rst_n & ps2_en_s;
    assign hz.ps1_flush = rst_n & ps1_flush_s;
    assign hz.ps2_flush = rst_n & ps2_flush_s;
    assign hz.halted    = rst_n & halted_s;
    assign hz.fwd_a_sel = rst_n ? fwd_a_s : 2'd0;
    assign hz.fwd_b_sel = rst_n ? fwd_b_s : 2'd0;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             stall_inc_s;
    logic             flush_inc_s;
    logic             halt_inc_s;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] halt_cycles_q;

    assign stall_inc_s = (state_q == ST_RUN) && !hlt_s && !hz.branch_taken && ldu_s;
    assign flush_inc_s = (state_q == ST_RUN) && !hlt_s && hz.branch_taken;
    assign halt_inc_s  = (state_q == ST_DRAIN) || (state_q == ST_HALTED);

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q   <= {CNT_W{1'b0}};
            halt_cycles_q <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s) stall_cnt_q   <= stall_cnt_q + CNT_ONE;
            if (flush_inc_s) flush_cnt_q   <= flush_cnt_q + CNT_ONE;
            if (halt_inc_s)  halt_cycles_q <= halt_cycles_q + CNT_ONE;
        end
    end

    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
    assign hz.halt_cycles = halt_cycles_q;
`else
    assign hz.stall_cnt   = {CNT_W{1'b0}};
    assign hz.flush_cnt   = {CNT_W{1'b0}};
    assign hz.halt_cycles = {CNT_W{1'b0}};
`endif

endmodule
